// File: rtl/dsp_wdata_channel.sv
// W-channel dispatcher for one AXI4 master port: buffers master W beats and
// steers each burst to the slave port queued by the AW dispatcher, in AW order.

module dsp_wdata_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (wr_en_i) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data_i;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en_i) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

module dsp_wdata_channel #(
  parameter int SLV_AMT        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int W_FIFO_DEPTH   = 4,
  parameter int DST_FIFO_DEPTH = 4,
  parameter int SLV_ID_W       = $clog2(SLV_AMT)
) (
  input  logic                           ACLK_i,
  input  logic                           ARESETn_i,
  input  logic [DATA_WIDTH-1:0]          m_WDATA_i,
  input  logic [DATA_WIDTH/8-1:0]        m_WSTRB_i,
  input  logic                           m_WLAST_i,
  input  logic                           m_WVALID_i,
  output logic                           m_WREADY_o,
  output logic [DATA_WIDTH*SLV_AMT-1:0]  sa_WDATA_o,
  output logic [DATA_WIDTH/8*SLV_AMT-1:0] sa_WSTRB_o,
  output logic [SLV_AMT-1:0]             sa_WLAST_o,
  output logic [SLV_AMT-1:0]             sa_WVALID_o,
  input  logic [SLV_AMT-1:0]             sa_WREADY_i,
  input  logic [SLV_ID_W-1:0]            dsp_AW_slv_id_i,
  input  logic                           dsp_AW_push_i,
  output logic                           dsp_AW_full_o,
  output logic                           dsp_W_burst_done_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BEAT_W = DATA_WIDTH + STRB_W + 1;

  logic                  m_hs;
  logic                  s_hs;
  logic                  fire;
  logic                  dst_push;
  logic                  dst_pop;
  logic                  wfifo_full;
  logic                  wfifo_empty;
  logic                  dst_full;
  logic                  dst_empty;
  logic [BEAT_W-1:0]     w_beat_in;
  logic [BEAT_W-1:0]     w_head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [STRB_W-1:0]     head_strb;
  logic                  head_last;
  logic [SLV_ID_W-1:0]   dst_head;
  logic [SLV_AMT-1:0]    sel_valid;

  assign m_WREADY_o = ~wfifo_full;
  assign m_hs       = m_WVALID_i & ~wfifo_full;
  assign w_beat_in  = {m_WLAST_i, m_WSTRB_i, m_WDATA_i};

  dsp_wdata_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (W_FIFO_DEPTH)
  ) u_w_fifo (
    .clk       (ACLK_i),
    .rst_n     (ARESETn_i),
    .wr_en_i   (m_hs),
    .wr_data_i (w_beat_in),
    .rd_en_i   (s_hs),
    .rd_data_o (w_head),
    .full_o    (wfifo_full),
    .empty_o   (wfifo_empty)
  );

  // A push into a full queue still lands when the head burst retires this cycle.
  assign dst_push = dsp_AW_push_i & (~dst_full | dst_pop);

  dsp_wdata_fifo #(
    .WIDTH (SLV_ID_W),
    .DEPTH (DST_FIFO_DEPTH)
  ) u_dst_fifo (
    .clk       (ACLK_i),
    .rst_n     (ARESETn_i),
    .wr_en_i   (dst_push),
    .wr_data_i (dsp_AW_slv_id_i),
    .rd_en_i   (dst_pop),
    .rd_data_o (dst_head),
    .full_o    (dst_full),
    .empty_o   (dst_empty)
  );

  assign {head_last, head_strb, head_data} = w_head;
  assign fire = ~wfifo_empty & ~dst_empty;

  always_comb begin
    sel_valid = '0;
    for (int k = 0; k < SLV_AMT; k++) begin
      sel_valid[k] = fire && (dst_head == SLV_ID_W'(k));
    end
  end

  assign s_hs    = |(sel_valid & sa_WREADY_i);
  assign dst_pop = s_hs & head_last;

  assign sa_WVALID_o        = sel_valid;
  assign sa_WDATA_o         = {SLV_AMT{head_data}};
  assign sa_WSTRB_o         = {SLV_AMT{head_strb}};
  assign sa_WLAST_o         = {SLV_AMT{head_last}};
  assign dsp_AW_full_o      = dst_full;
  assign dsp_W_burst_done_o = dst_pop;

endmodule

// File: tb/tb_dsp_wdata_channel.sv
// Scoreboard bench for dsp_wdata_channel: stimulus queues expected beats and
// destinations, a negedge monitor pairs them burst-by-burst against the outputs.

module tb_dsp_wdata_channel;
  localparam int SLV_AMT = 2;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int DEPTH   = 4;
  localparam int NB      = 30;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [DW-1:0]         m_WDATA_i;
  logic [SW-1:0]         m_WSTRB_i;
  logic                  m_WLAST_i;
  logic                  m_WVALID_i;
  logic                  m_WREADY_o;
  logic [DW*SLV_AMT-1:0] sa_WDATA_o;
  logic [SW*SLV_AMT-1:0] sa_WSTRB_o;
  logic [SLV_AMT-1:0]    sa_WLAST_o;
  logic [SLV_AMT-1:0]    sa_WVALID_o;
  logic [SLV_AMT-1:0]    sa_WREADY_i;
  logic [0:0]            dsp_AW_slv_id_i;
  logic                  dsp_AW_push_i;
  logic                  dsp_AW_full_o;
  logic                  dsp_W_burst_done_o;

  dsp_wdata_channel #(
    .SLV_AMT        (SLV_AMT),
    .DATA_WIDTH     (DW),
    .W_FIFO_DEPTH   (DEPTH),
    .DST_FIFO_DEPTH (DEPTH),
    .SLV_ID_W       (1)
  ) dut (
    .ACLK_i             (clk),
    .ARESETn_i          (rst_n),
    .m_WDATA_i          (m_WDATA_i),
    .m_WSTRB_i          (m_WSTRB_i),
    .m_WLAST_i          (m_WLAST_i),
    .m_WVALID_i         (m_WVALID_i),
    .m_WREADY_o         (m_WREADY_o),
    .sa_WDATA_o         (sa_WDATA_o),
    .sa_WSTRB_o         (sa_WSTRB_o),
    .sa_WLAST_o         (sa_WLAST_o),
    .sa_WVALID_o        (sa_WVALID_o),
    .sa_WREADY_i        (sa_WREADY_i),
    .dsp_AW_slv_id_i    (dsp_AW_slv_id_i),
    .dsp_AW_push_i      (dsp_AW_push_i),
    .dsp_AW_full_o      (dsp_AW_full_o),
    .dsp_W_burst_done_o (dsp_W_burst_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_ids[$];
  int    checks   = 0;
  int    failures = 0;
  bit    stop_rdy = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: model state is what the DUT should hold between edges.
  initial begin : monitor
    logic  rst_prev;
    int    hd;
    beat_t b;
    logic  pop;
    rst_prev = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_beats.delete();
        exp_ids.delete();
        if (!rst_prev) begin
          chk("rst_wvalid", sa_WVALID_o, 0);
          chk("rst_wready", m_WREADY_o, 1);
          chk("rst_aw_full", dsp_AW_full_o, 0);
          chk("rst_done", dsp_W_burst_done_o, 0);
        end
      end else begin
        chk("m_wready", m_WREADY_o, exp_beats.size() < DEPTH);
        chk("aw_full", dsp_AW_full_o, exp_ids.size() == DEPTH);
        if (dsp_AW_push_i) begin
          chk("aw_id_range", 64'(dsp_AW_slv_id_i) < SLV_AMT, 1);
          chk("aw_push_while_full", dsp_AW_full_o & ~dsp_W_burst_done_o, 0);
        end
        if (exp_beats.size() > 0 && exp_ids.size() > 0) begin
          hd = exp_ids[0];
          b  = exp_beats[0];
          chk("sa_wvalid", sa_WVALID_o, 64'(1) << hd);
          for (int k = 0; k < SLV_AMT; k++) begin
            chk($sformatf("sa_wdata[%0d]", k), sa_WDATA_o[k*DW +: DW], b.d);
            chk($sformatf("sa_wstrb[%0d]", k), sa_WSTRB_o[k*SW +: SW], b.s);
            chk($sformatf("sa_wlast[%0d]", k), sa_WLAST_o[k], b.l);
          end
          pop = sa_WREADY_i[hd];
          chk("burst_done", dsp_W_burst_done_o, pop & b.l);
          if (pop) begin
            void'(exp_beats.pop_front());
            if (b.l) void'(exp_ids.pop_front());
          end
        end else begin
          chk("sa_wvalid_idle", sa_WVALID_o, 0);
          chk("burst_done_idle", dsp_W_burst_done_o, 0);
        end
      end
      rst_prev = rst_n;
    end
  end

  initial begin : watchdog
    #400000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    bit    acc;
    logic  rdy;
    beat_t b;
    m_WVALID_i = 1'b1;
    m_WDATA_i  = d;
    m_WSTRB_i  = s;
    m_WLAST_i  = l;
    acc        = 0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      rdy = m_WREADY_o;
      @(posedge clk);
      if (rdy) begin
        b.d = d;
        b.s = s;
        b.l = l;
        exp_beats.push_back(b);
        acc = 1;
      end
      #1;
    end
    m_WVALID_i = 1'b0;
    chk("w_accept_timeout", acc, 1);
  endtask

  task automatic push_id(input int id);
    dsp_AW_push_i   = 1'b1;
    dsp_AW_slv_id_i = 1'(id);
    @(posedge clk);
    exp_ids.push_back(id);
    #1;
    dsp_AW_push_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_beats.size() > 0 || exp_ids.size() > 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", exp_beats.size() == 0 && exp_ids.size() == 0, 1);
  endtask

  initial begin : stimulus
    rst_n           = 1'b0;
    m_WVALID_i      = 1'b1;
    m_WDATA_i       = 32'hDEAD_BEEF;
    m_WSTRB_i       = 4'hF;
    m_WLAST_i       = 1'b1;
    sa_WREADY_i     = 2'b11;
    dsp_AW_push_i   = 1'b0;
    dsp_AW_slv_id_i = 1'b0;
    idle(2);
    rst_n      = 1'b1;
    m_WVALID_i = 1'b0;
    @(negedge clk);
    chk("idle_wready", m_WREADY_o, 1);
    chk("idle_wvalid", sa_WVALID_o, 2'b00);
    chk("idle_aw_full", dsp_AW_full_o, 0);
    @(posedge clk);
    #1;

    // Single 4-beat burst to port 1.
    push_id(1);
    for (int i = 0; i < 4; i++) drive_beat(32'hA0 + i, 4'hF, i == 3);
    wait_drain();

    // W data ahead of its AW.
    drive_beat(32'hB0, 4'hF, 1'b0);
    drive_beat(32'hB1, 4'hF, 1'b1);
    idle(3);
    push_id(0);
    wait_drain();

    // Port 0 stalls; port 1 burst must wait behind it and the W FIFO fills.
    sa_WREADY_i = 2'b10;
    push_id(0);
    push_id(1);
    for (int i = 0; i < 4; i++) drive_beat(32'hC0 + i, 4'h3 << i, (i % 2) == 1);
    @(negedge clk);
    chk("wready_drop", m_WREADY_o, 0);
    chk("p1_blocked", sa_WVALID_o, 2'b01);
    @(posedge clk);
    #1;
    idle(2);
    sa_WREADY_i = 2'b11;
    wait_drain();

    // Destination queue full, then push coinciding with a WLAST pop.
    push_id(0);
    push_id(1);
    push_id(0);
    push_id(1);
    @(negedge clk);
    chk("aw_full_set", dsp_AW_full_o, 1);
    @(posedge clk);
    #1;
    drive_beat(32'hD0, 4'hF, 1'b1);
    push_id(1);
    @(negedge clk);
    chk("aw_full_kept", dsp_AW_full_o, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) drive_beat(32'hD0 + i, 4'hF, 1'b1);
    wait_drain();

    // Reset in the middle of a burst.
    sa_WREADY_i = 2'b00;
    push_id(0);
    drive_beat(32'hE0, 4'hF, 1'b0);
    drive_beat(32'hE1, 4'hF, 1'b0);
    rst_n      = 1'b0;
    m_WVALID_i = 1'b1;
    m_WDATA_i  = 32'hE2;
    m_WLAST_i  = 1'b0;
    idle(1);
    rst_n      = 1'b1;
    m_WVALID_i = 1'b0;
    @(negedge clk);
    chk("midrst_wvalid", sa_WVALID_o, 2'b00);
    chk("midrst_aw_full", dsp_AW_full_o, 0);
    chk("midrst_wready", m_WREADY_o, 1);
    @(posedge clk);
    #1;
    sa_WREADY_i = 2'b11;
    push_id(1);
    drive_beat(32'hF0, 4'h5, 1'b1);
    wait_drain();

    // Randomized traffic with random slave back-pressure.
    stop_rdy = 0;
    fork
      begin : rdy_thr
        while (!stop_rdy) begin
          sa_WREADY_i = 2'($urandom_range(0, 3));
          @(posedge clk);
          #1;
        end
      end
    join_none
    fork
      begin : aw_thr
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < NB && guard < 5000) begin
          if (!dsp_AW_full_o && $urandom_range(0, 2) != 0) begin
            push_id(int'($urandom_range(0, SLV_AMT - 1)));
            sent++;
          end else begin
            idle(1);
          end
          guard++;
        end
      end
      begin : w_thr
        for (int b = 0; b < NB; b++) begin
          int len;
          len = int'($urandom_range(1, 4));
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive_beat($urandom, 4'($urandom), i == len - 1);
          end
        end
      end
    join
    stop_rdy = 1;
    idle(2);
    sa_WREADY_i = 2'b11;
    wait_drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
